// File: rtl/shift_io_expander.sv
// Master controller for a 74HC165 (input) / 74HC595 (output) shift-register chain.
// One transaction: parallel-load '165, shift WIDTH bits both ways MSB-first, latch '595.
module shift_io_expander #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_out_data,
  output logic [WIDTH-1:0] o_in_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sr_clk,
  output logic             o_sr_load_n,
  output logic             o_sr_latch,
  output logic             o_sr_dout,
  input  logic             i_sr_din
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StLatch,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [DivW-1:0]   r_div;
  logic [DivW-1:0]   w_div_d;
  logic [BitW-1:0]   r_bit;
  logic [BitW-1:0]   w_bit_d;
  logic [WIDTH-1:0]  r_tx;
  logic [WIDTH-1:0]  w_tx_d;
  logic [WIDTH-1:0]  r_rx;
  logic [WIDTH-1:0]  w_rx_d;
  logic [1:0]        r_sync;
  logic              w_div_last;

  logic [WIDTH-1:0]  r_in_data;
  logic              r_busy;
  logic              r_done;
  logic              r_sr_clk;
  logic              r_sr_load_n;
  logic              r_sr_latch;
  logic              r_sr_dout;

  assign w_div_last = (r_div == DivW'(CLK_DIV - 1));

  always_comb begin
    w_state_d = r_state;
    w_div_d   = r_div;
    w_bit_d   = r_bit;
    w_tx_d    = r_tx;
    w_rx_d    = r_rx;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StLoad;
          w_div_d   = '0;
          w_bit_d   = '0;
          w_tx_d    = i_out_data;
        end
      end
      StLoad: begin
        if (w_div_last) begin
          w_state_d = StShiftLo;
          w_div_d   = '0;
        end else begin
          w_div_d = r_div + DivW'(1);
        end
      end
      StShiftLo: begin
        if (w_div_last) begin
          // Late in the low phase so the synchronizer has settled on the '165 output.
          w_rx_d    = {r_rx[WIDTH-2:0], r_sync[1]};
          w_state_d = StShiftHi;
          w_div_d   = '0;
        end else begin
          w_div_d = r_div + DivW'(1);
        end
      end
      StShiftHi: begin
        if (w_div_last) begin
          w_tx_d    = {r_tx[WIDTH-2:0], 1'b0};
          w_bit_d   = r_bit + BitW'(1);
          w_div_d   = '0;
          w_state_d = (r_bit == BitW'(WIDTH - 1)) ? StLatch : StShiftLo;
        end else begin
          w_div_d = r_div + DivW'(1);
        end
      end
      StLatch: begin
        if (w_div_last) begin
          w_state_d = StDone;
          w_div_d   = '0;
        end else begin
          w_div_d = r_div + DivW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_div       <= '0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_sync      <= '0;
      r_in_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sr_clk    <= 1'b0;
      r_sr_load_n <= 1'b1;
      r_sr_latch  <= 1'b0;
      r_sr_dout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_div       <= w_div_d;
      r_bit       <= w_bit_d;
      r_tx        <= w_tx_d;
      r_rx        <= w_rx_d;
      r_sync      <= {r_sync[0], i_sr_din};
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone);
      r_sr_clk    <= (w_state_d == StShiftHi);
      r_sr_load_n <= (w_state_d != StLoad);
      r_sr_latch  <= (w_state_d == StLatch);
      if (w_state_d == StLoad || w_state_d == StShiftLo) begin
        r_sr_dout <= w_tx_d[WIDTH-1];
      end
      if (w_state_d == StDone) begin
        r_in_data <= w_rx_d;
      end
    end
  end

  assign o_in_data   = r_in_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sr_clk    = r_sr_clk;
  assign o_sr_load_n = r_sr_load_n;
  assign o_sr_latch  = r_sr_latch;
  assign o_sr_dout   = r_sr_dout;

endmodule

// File: tb/tb_shift_io_expander.sv
// Bench for shift_io_expander: behavioural '165/'595 chain models, scoreboard of
// expected transfers checked on each done pulse, plus a small WIDTH=8/CLK_DIV=3 instance.
module tb_shift_io_expander;

  localparam int unsigned W     = 24;
  localparam int unsigned CD    = 2;
  localparam int unsigned W2    = 8;
  localparam int unsigned CD2   = 3;
  localparam int unsigned BusyA = CD * (2 * W + 2) + 1;
  localparam int unsigned BusyB = CD2 * (2 * W2 + 2) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         start_a = 1'b0;
  logic [W-1:0] out_a = '0;
  logic [W-1:0] in_a;
  logic         busy_a, done_a, sclk_a, load_n_a, latch_a, dout_a, din_a;

  logic          start_b = 1'b0;
  logic [W2-1:0] out_b = '0;
  logic [W2-1:0] in_b;
  logic          busy_b, done_b, sclk_b, load_n_b, latch_b, dout_b, din_b;

  shift_io_expander #(.WIDTH(W), .CLK_DIV(CD)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_out_data(out_a),
    .o_in_data(in_a), .o_busy(busy_a), .o_done(done_a), .o_sr_clk(sclk_a),
    .o_sr_load_n(load_n_a), .o_sr_latch(latch_a), .o_sr_dout(dout_a), .i_sr_din(din_a)
  );

  shift_io_expander #(.WIDTH(W2), .CLK_DIV(CD2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_out_data(out_b),
    .o_in_data(in_b), .o_busy(busy_b), .o_done(done_b), .o_sr_clk(sclk_b),
    .o_sr_load_n(load_n_b), .o_sr_latch(latch_b), .o_sr_dout(dout_b), .i_sr_din(din_b)
  );

  // External chain models: '165 loads asynchronously while load_n is low, shifts toward QH
  // on each shift-clock rise; '595 shifts on the rise and copies to outputs on latch rise.
  logic [W-1:0]  pat_a = '0, c165_a = '0, s595_a = '0, lat595_a = '0;
  logic [W2-1:0] pat_b = '0, c165_b = '0, s595_b = '0, lat595_b = '0;

  always @(posedge sclk_a or negedge load_n_a)
    if (!load_n_a) c165_a <= pat_a;
    else           c165_a <= {c165_a[W-2:0], 1'b0};
  always @(posedge sclk_a) s595_a <= {s595_a[W-2:0], dout_a};
  always @(posedge latch_a) lat595_a <= s595_a;
  assign din_a = c165_a[W-1];

  always @(posedge sclk_b or negedge load_n_b)
    if (!load_n_b) c165_b <= pat_b;
    else           c165_b <= {c165_b[W2-2:0], 1'b0};
  always @(posedge sclk_b) s595_b <= {s595_b[W2-2:0], dout_b};
  always @(posedge latch_b) lat595_b <= s595_b;
  assign din_b = c165_b[W2-1];

  typedef struct packed {
    logic [W-1:0] in_exp;
    logic [W-1:0] out_exp;
  } exp_t;
  exp_t sb[$];

  int n_total = 0, n_pass = 0;
  int n_done_exp = 0, n_done_seen = 0;
  int rises_a = 0, lrises_a = 0, busy_cyc_a = 0, inv_err = 0;
  logic prev_sclk_a = 1'b0, prev_latch_a = 1'b0, prev_dout_a = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every done pulse of instance A.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rises_a = 0; lrises_a = 0; busy_cyc_a = 0;
    end else begin
      if (!busy_a) begin
        rises_a = 0; lrises_a = 0; busy_cyc_a = 0;
      end else begin
        busy_cyc_a++;
      end
      if (sclk_a && !prev_sclk_a) rises_a++;
      if (latch_a && !prev_latch_a) lrises_a++;
      if (!load_n_a && (latch_a || sclk_a)) inv_err++;
      if (sclk_a && prev_sclk_a && dout_a != prev_dout_a) inv_err++;
      if (latch_a && rises_a != W) inv_err++;
      if (done_a) begin
        n_done_seen++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done pulse, required none");
        end else begin
          e = sb.pop_front();
          check("in_data", in_a, e.in_exp);
          check("latched_595", lat595_a, e.out_exp);
          check("sclk_rises", W'(rises_a), W'(W));
          check("latch_rises", W'(lrises_a), W'(1));
          check("busy_cycles", W'(busy_cyc_a), W'(BusyA));
        end
      end
    end
    prev_sclk_a  = sclk_a;
    prev_latch_a = latch_a;
    prev_dout_a  = dout_a;
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
    if (busy_a) begin
      n_total++;
      $display("FAIL idle_timeout: got busy, required idle");
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !done_a; i++) @(negedge clk);
    if (!done_a) begin
      n_total++;
      $display("FAIL done_timeout: got no done, required done");
    end
  endtask

  // Issues one transfer; optionally pokes start at cycles 5 and 60 while busy.
  task automatic run_txn(input logic [W-1:0] od, input logic [W-1:0] ip, input bit intrude);
    wait_idle();
    pat_a   = ip;
    out_a   = od;
    start_a = 1'b1;
    sb.push_back('{in_exp: ip, out_exp: od});
    n_done_exp++;
    @(negedge clk);
    start_a = 1'b0;
    out_a   = W'($urandom);
    if (intrude) begin
      repeat (4) @(negedge clk);
      out_a = 24'h123456; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (54) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
  endtask

  logic [W-1:0] lat_before;
  int cnt_b, dn_b;
  logic [W2-1:0] got_in_b, got_lat_b;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", W'({busy_a, done_a, sclk_a, load_n_a, latch_a, dout_a}), W'(6'b000100));
    check("reset_in_data", in_a, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(24'h5A0FF1, 24'hA5C33C, 1'b1);
    run_txn(24'h000000, 24'h000000, 1'b0);
    run_txn(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    run_txn(24'h800001, 24'h800001, 1'b0);

    // Back-to-back: start in the first idle cycle after done.
    run_txn(24'hC0FFEE, 24'h13579B, 1'b0);
    wait_done();
    @(negedge clk);
    run_txn(24'h2468AC, 24'hFEDCBA, 1'b0);

    // start during the DONE cycle is ignored.
    wait_done();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_in_done_ignored", W'(busy_a), W'(0));

    // Reset after 10 shift-clock rises discards the transfer.
    run_txn(24'h3C3C3C, 24'h5A5A5A, 1'b0);
    lat_before = lat595_a;
    for (int i = 0; i < 400 && rises_a < 10; i++) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    n_done_exp--;
    @(negedge clk);
    check("midreset_outputs", W'({busy_a, done_a, sclk_a, load_n_a, latch_a, dout_a}),
          W'(6'b000100));
    check("midreset_in_data", in_a, '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_latch", lat595_a, lat_before);
    run_txn(24'h00F00F, 24'h00F00F, 1'b0);

    for (int k = 0; k < 6; k++) run_txn(W'($urandom), W'($urandom), 1'b0);

    wait_idle();
    repeat (3) @(negedge clk);
    check("done_count", W'(n_done_seen), W'(n_done_exp));
    check("pin_invariants", W'(inv_err), W'(0));

    // Second geometry: WIDTH=8, CLK_DIV=3.
    pat_b = 8'h96; out_b = 8'h3C; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; out_b = 8'hFF;
    cnt_b = 0; dn_b = 0; got_in_b = '0; got_lat_b = '0;
    while (busy_b && cnt_b < 200) begin
      cnt_b++;
      if (done_b) begin
        dn_b++;
        got_in_b  = in_b;
        got_lat_b = lat595_b;
      end
      @(negedge clk);
    end
    check("b_in_data", W'(got_in_b), W'(8'h96));
    check("b_latched_595", W'(got_lat_b), W'(8'h3C));
    check("b_busy_cycles", W'(cnt_b), W'(BusyB));
    check("b_done_pulses", W'(dn_b), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
